// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the inter-stage pipeline registers of the five-stage
// MIPS core: the reset PC, the NOP encoding, stall source indices, the width of
// the stall statistics counter and the flush-pending state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package pipe_pkg;

   // PC loaded on reset and carried by reset bubbles
   localparam logic [31:0] PIPE_RESET_PC = 32'h0000_3000;

   // sll $0,$0,0 -- all-zero word decodes as NOP
   localparam logic [31:0] PIPE_NOP = 32'h0000_0000;

   // Bit positions of the stall request sources in stall_req
   localparam int STALL_HAZ   = 0;
   localparam int STALL_BUSY  = 1;
   localparam int STALL_START = 2;

   // Width of the consecutive-stall statistics counter
   localparam int STALL_CTR_W = 16;

   // Remembers a flush that arrived while the stage was stalled
   typedef enum logic {
      FP_IDLE = 1'b0,
      FP_PEND = 1'b1
   } flush_st_e;

endpackage : pipe_pkg

// File: rtl/pipe_stall_ctr.sv
// -----------------------------------------------------------------------------
// pipe_stall_ctr
// Saturating counter of consecutive stalled cycles, used for performance debug.
// Counts up by one on every edge with i_stall=1, saturates at all-ones, and
// clears on the first edge with i_stall=0 and on reset.
// Ports:
//   clk      in   clock, posedge
//   reset    in   synchronous, active-high
//   i_stall  in   stage is stalled this cycle
//   o_count  out  registered count of consecutive stalled cycles
// -----------------------------------------------------------------------------
module pipe_stall_ctr
   import pipe_pkg::*;
#(
   parameter int W = STALL_CTR_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_stall,
   output logic [W-1:0] o_count
);

   logic [W-1:0] r_count;

   // Count consecutive stalled edges, holding at the all-ones ceiling
   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= {W{1'b0}};
      end else if (!i_stall) begin
         r_count <= {W{1'b0}};
      end else if (r_count != {W{1'b1}}) begin
         r_count <= r_count + {{(W-1){1'b0}}, 1'b1};
      end else begin
         r_count <= r_count;
      end
   end

   assign o_count = r_count;

endmodule : pipe_stall_ctr

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// Parametrised register between two adjacent stages of the MIPS pipeline.
// Carries payload, PC, valid and branch-delay flag. Any stall request holds
// the stage; a flush loads a bubble (valid=0, payload=NOP, PC/bd kept for
// exception reporting). A flush seen during a stall is remembered and applied
// at the first non-stalled edge. Invalid input always loads a NOP payload.
//
// Optional feature macro: PIPE_STALL_STATS_EN
//   defined   -> stall_cycles counts consecutive stalled cycles (saturating)
//   undefined -> no counter, stall_cycles tied to zero
//
// Ports:
//   clk           in   clock, posedge
//   reset         in   synchronous, active-high
//   stall_req     in   [NSTALL] per-source stall requests
//   flush         in   squash the instruction entering this stage
//   in_valid      in   upstream slot holds a real instruction
//   in_data       in   [DATA_W] upstream payload
//   in_pc         in   [32] upstream PC
//   in_bd         in   upstream instruction is in a branch delay slot
//   out_valid     out  registered valid
//   out_data      out  [DATA_W] registered payload
//   out_pc        out  [32] registered PC
//   out_bd        out  registered delay-slot flag
//   stalled       out  combinational OR of stall_req
//   stall_cycles  out  [16] consecutive stalled cycles (0 when stats disabled)
// -----------------------------------------------------------------------------
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int          DATA_W   = 32,
   parameter int          NSTALL   = 3,
   parameter logic [31:0] RESET_PC = PIPE_RESET_PC
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NSTALL-1:0]      stall_req,
   input  logic                   flush,
   input  logic                   in_valid,
   input  logic [DATA_W-1:0]      in_data,
   input  logic [31:0]            in_pc,
   input  logic                   in_bd,
   output logic                   out_valid,
   output logic [DATA_W-1:0]      out_data,
   output logic [31:0]            out_pc,
   output logic                   out_bd,
   output logic                   stalled,
   output logic [STALL_CTR_W-1:0] stall_cycles
);

   logic              w_stall;
   logic              w_en;
   logic              w_bubble;
   flush_st_e         r_fstate;
   logic              r_valid;
   logic [DATA_W-1:0] r_data;
   logic [31:0]       r_pc;
   logic              r_bd;

   assign w_stall  = |stall_req;
   assign w_en     = ~w_stall;
   // A live flush or one remembered from an earlier stall both squash the load
   assign w_bubble = flush | (r_fstate == FP_PEND);

   // Stage register and flush-pending state machine; priority reset > stall > flush > load
   always_ff @(posedge clk) begin
      if (reset) begin
         r_fstate <= FP_IDLE;
         r_valid  <= 1'b0;
         r_data   <= {DATA_W{1'b0}};
         r_pc     <= RESET_PC;
         r_bd     <= 1'b0;
      end else if (!w_en) begin
         // Outputs hold; a flush arriving now must survive until the stall ends
         r_valid <= r_valid;
         r_data  <= r_data;
         r_pc    <= r_pc;
         r_bd    <= r_bd;
         case (r_fstate)
            FP_IDLE: r_fstate <= flush ? FP_PEND : FP_IDLE;
            FP_PEND: r_fstate <= FP_PEND;
            default: r_fstate <= FP_IDLE;
         endcase
      end else if (w_bubble) begin
         // PC and delay-slot flag are kept so the bubble can still report EPC
         r_fstate <= FP_IDLE;
         r_valid  <= 1'b0;
         r_data   <= {DATA_W{1'b0}};
         r_pc     <= in_pc;
         r_bd     <= in_bd;
      end else begin
         r_fstate <= FP_IDLE;
         r_valid  <= in_valid;
         // Downstream decode must see NOP on every bubble, whatever in_data holds
         r_data   <= in_valid ? in_data : {DATA_W{1'b0}};
         r_pc     <= in_pc;
         r_bd     <= in_bd;
      end
   end

   assign out_valid = r_valid;
   assign out_data  = r_data;
   assign out_pc    = r_pc;
   assign out_bd    = r_bd;
   assign stalled   = w_stall;

`ifdef PIPE_STALL_STATS_EN
   pipe_stall_ctr #(
      .W (STALL_CTR_W)
   ) u_stall_ctr (
      .clk     (clk),
      .reset   (reset),
      .i_stall (w_stall),
      .o_count (stall_cycles)
   );
`else
   assign stall_cycles = 16'h0000;
`endif

endmodule : pipe_stage_reg

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
// Directed self-checking bench for pipe_stage_reg (default parameters).
// Follows PIPE_STALL_STATS_EN to choose the expected stall_cycles values.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

   logic        clk;
   logic        reset;
   logic [2:0]  stall_req;
   logic        flush;
   logic        in_valid;
   logic [31:0] in_data;
   logic [31:0] in_pc;
   logic        in_bd;
   logic        out_valid;
   logic [31:0] out_data;
   logic [31:0] out_pc;
   logic        out_bd;
   logic        stalled;
   logic [15:0] stall_cycles;

   int total;
   int bad;

`ifdef PIPE_STALL_STATS_EN
   localparam bit STATS_ON = 1'b1;
`else
   localparam bit STATS_ON = 1'b0;
`endif

   pipe_stage_reg #(
      .DATA_W   (32),
      .NSTALL   (3),
      .RESET_PC (32'h0000_3000)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .stall_req    (stall_req),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_pc        (in_pc),
      .in_bd        (in_bd),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_pc       (out_pc),
      .out_bd       (out_bd),
      .stalled      (stalled),
      .stall_cycles (stall_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge; inputs change and outputs are sampled 1 time unit after it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; stall_req = 3'b000; flush = 1'b0;
      in_valid = 1'b1; in_data = 32'hFFFF_FFFF; in_pc = 32'h1234_5678; in_bd = 1'b1;
      step(); step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", out_valid); end
      total++; if (out_data !== 32'h0) begin bad++; $display("FAIL rst_data got=%h want=00000000", out_data); end
      total++; if (out_pc !== 32'h0000_3000) begin bad++; $display("FAIL rst_pc got=%h want=00003000", out_pc); end
      total++; if (out_bd !== 1'b0) begin bad++; $display("FAIL rst_bd got=%b want=0", out_bd); end
      total++; if (stall_cycles !== 16'h0) begin bad++; $display("FAIL rst_cycles got=%h want=0000", stall_cycles); end
      reset = 1'b0; in_bd = 1'b0;
      in_valid = 1'b1; in_data = 32'h2408_0005; in_pc = 32'h0000_3000;
      step();
      total++; if (out_data !== 32'h2408_0005) begin bad++; $display("FAIL first_data got=%h want=24080005", out_data); end
      total++; if (out_pc !== 32'h0000_3000) begin bad++; $display("FAIL first_pc got=%h want=00003000", out_pc); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL first_valid got=%b want=1", out_valid); end
   endtask

   task automatic test_multi_stall();
      in_data = 32'h1111_1111; in_pc = 32'h0000_3004;
      step();
      stall_req = 3'b010;
      for (int i = 0; i < 3; i++) begin
         in_data = 32'hA000_0000 + 32'(i); in_pc = 32'h0000_4000 + 32'(i);
         step();
         total++; if (out_data !== 32'h1111_1111) begin bad++; $display("FAIL stall_hold_data[%0d] got=%h want=11111111", i, out_data); end
         total++; if (out_pc !== 32'h0000_3004) begin bad++; $display("FAIL stall_hold_pc[%0d] got=%h want=00003004", i, out_pc); end
         total++; if (stalled !== 1'b1) begin bad++; $display("FAIL stalled[%0d] got=%b want=1", i, stalled); end
         total++; if (stall_cycles !== (STATS_ON ? 16'(i + 1) : 16'h0)) begin
            bad++; $display("FAIL stall_cnt[%0d] got=%0d want=%0d", i, stall_cycles, STATS_ON ? i + 1 : 0);
         end
      end
      stall_req = 3'b000; in_data = 32'h2222_2222; in_pc = 32'h0000_3008;
      #1;
      total++; if (stalled !== 1'b0) begin bad++; $display("FAIL stalled_release got=%b want=0", stalled); end
      step();
      total++; if (out_data !== 32'h2222_2222) begin bad++; $display("FAIL release_data got=%h want=22222222", out_data); end
      total++; if (stall_cycles !== 16'h0) begin bad++; $display("FAIL release_cnt got=%0d want=0", stall_cycles); end
   endtask

   task automatic test_live_flush();
      flush = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD_BEEF; in_pc = 32'h0000_3010; in_bd = 1'b1;
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lflush_valid got=%b want=0", out_valid); end
      total++; if (out_data !== 32'h0) begin bad++; $display("FAIL lflush_data got=%h want=00000000", out_data); end
      total++; if (out_pc !== 32'h0000_3010) begin bad++; $display("FAIL lflush_pc got=%h want=00003010", out_pc); end
      total++; if (out_bd !== 1'b1) begin bad++; $display("FAIL lflush_bd got=%b want=1", out_bd); end
      flush = 1'b0; in_bd = 1'b0; in_data = 32'h3333_3333; in_pc = 32'h0000_3014;
      step();
      total++; if (out_valid !== 1'b1 || out_data !== 32'h3333_3333) begin
         bad++; $display("FAIL lflush_after got=%b/%h want=1/33333333", out_valid, out_data);
      end
   endtask

   task automatic test_pending_flush();
      stall_req = 3'b001; flush = 1'b1; in_data = 32'h4444_4444; in_pc = 32'h0000_3018;
      step();
      flush = 1'b0;
      for (int i = 0; i < 3; i++) begin
         total++; if (out_valid !== 1'b1 || out_data !== 32'h3333_3333 || out_pc !== 32'h0000_3014) begin
            bad++; $display("FAIL pflush_hold[%0d] got=%b/%h/%h want=1/33333333/00003014", i, out_valid, out_data, out_pc);
         end
         step();
      end
      stall_req = 3'b000; in_data = 32'h5555_5555; in_pc = 32'h0000_301C;
      step();
      total++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_pc !== 32'h0000_301C) begin
         bad++; $display("FAIL pflush_bubble got=%b/%h/%h want=0/00000000/0000301c", out_valid, out_data, out_pc);
      end
      in_data = 32'h6666_6666; in_pc = 32'h0000_3020;
      step();
      total++; if (out_valid !== 1'b1 || out_data !== 32'h6666_6666 || out_pc !== 32'h0000_3020) begin
         bad++; $display("FAIL pflush_next got=%b/%h/%h want=1/66666666/00003020", out_valid, out_data, out_pc);
      end
   endtask

   task automatic test_reset_pending();
      stall_req = 3'b001; flush = 1'b1;
      step();
      flush = 1'b0; reset = 1'b1;
      step();
      total++; if (out_valid !== 1'b0 || out_pc !== 32'h0000_3000) begin
         bad++; $display("FAIL rpend_reset got=%b/%h want=0/00003000", out_valid, out_pc);
      end
      total++; if (stall_cycles !== 16'h0) begin bad++; $display("FAIL rpend_cnt got=%0d want=0", stall_cycles); end
      reset = 1'b0; stall_req = 3'b000;
      in_valid = 1'b1; in_data = 32'h8C09_0000; in_pc = 32'h0000_3024;
      step();
      total++; if (out_valid !== 1'b1 || out_data !== 32'h8C09_0000) begin
         bad++; $display("FAIL rpend_load got=%b/%h want=1/8c090000", out_valid, out_data);
      end
   endtask

   task automatic test_invalid_input();
      in_valid = 1'b0; in_data = 32'hFFFF_FFFF; in_pc = 32'h0000_3028; in_bd = 1'b1;
      step();
      total++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_pc !== 32'h0000_3028 || out_bd !== 1'b1) begin
         bad++; $display("FAIL invalid_in got=%b/%h/%h/%b want=0/00000000/00003028/1", out_valid, out_data, out_pc, out_bd);
      end
      in_valid = 1'b1; in_bd = 1'b0;
   endtask

   task automatic test_saturation();
      stall_req = 3'b111;
`ifdef PIPE_STALL_STATS_EN
      for (int i = 0; i < 65534; i++) step();
      total++; if (stall_cycles !== 16'hFFFE) begin bad++; $display("FAIL sat_fffe got=%h want=fffe", stall_cycles); end
      for (int i = 0; i < 6; i++) step();
      total++; if (stall_cycles !== 16'hFFFF) begin bad++; $display("FAIL sat_ffff got=%h want=ffff", stall_cycles); end
      step();
      total++; if (stall_cycles !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got=%h want=ffff", stall_cycles); end
`else
      for (int i = 0; i < 20; i++) begin
         step();
         total++; if (stall_cycles !== 16'h0) begin bad++; $display("FAIL nostats_cnt[%0d] got=%h want=0000", i, stall_cycles); end
      end
`endif
      stall_req = 3'b000;
      step();
      total++; if (stall_cycles !== 16'h0) begin bad++; $display("FAIL sat_release got=%h want=0000", stall_cycles); end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_multi_stall();
      test_live_flush();
      test_pending_flush();
      test_reset_pending();
      test_invalid_input();
      test_saturation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_pipe_stage_reg

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register for the five-stage MIPS core, the successor of the fixed IF/ID latch. It carries a generic payload word plus PC, a valid bit and a branch-delay flag between any two adjacent stages. It resolves an N-way stall request vector and a flush that is remembered across stalls. It can optionally count stall cycles for performance debug.

## Interface
Parameters:
- DATA_W, 32, payload width (instruction word or packed control bundle)
- NSTALL, 3, number of independent stall request sources (hazard unit, MDU BUSY, MDU start)
- RESET_PC, 32'h0000_3000, PC value loaded on reset and carried by bubbles

Ports:
- clk  in  1  clock, all state updates on posedge
- reset  in  1  synchronous, active-high
- stall_req  in  NSTALL  per-source stall requests; stage holds if any bit is 1
- flush  in  1  squash request for the instruction entering this stage
- in_valid  in  1  upstream slot holds a real instruction
- in_data  in  DATA_W  upstream payload
- in_pc  in  32  upstream PC
- in_bd  in  1  upstream instruction sits in a branch delay slot
- out_valid  out  1  registered valid
- out_data  out  DATA_W  registered payload
- out_pc  out  32  registered PC
- out_bd  out  1  registered delay-slot flag
- stalled  out  1  combinational OR of stall_req (the enable complement)
- stall_cycles  out  16  saturating count of consecutive stalled cycles

## Operation
- Enable: en = ~|stall_req. stalled = |stall_req.
- Priority at posedge, highest first: reset, then stall, then flush (live or pending), then load.
- Reset:
  - out_valid=0, out_data=0, out_pc=RESET_PC, out_bd=0.
  - flush_pend=0, stall_cycles=0.
- Stall (en=0):
  - All out_* hold their values.
  - If flush=1, set flush_pend=1. A flush is never lost behind a stall.
- Flush applied (en=1 and (flush|flush_pend)):
  - Load a bubble: out_valid=0, out_data=0 (NOP encoding).
  - out_pc=in_pc, out_bd=in_bd. The PC is kept for EPC/exception reporting.
  - Clear flush_pend.
- Load (en=1, no flush): out_valid=in_valid, out_data=in_data, out_pc=in_pc, out_bd=in_bd.
- Invalid input: in_valid=0 loads out_data=0, whatever in_data is, so downstream decode always sees NOP on bubbles.
- flush_pend state machine:
  - IDLE to PEND on stall&flush.
  - PEND to IDLE on the first en=1 cycle, which applies the bubble.
  - reset forces IDLE.

## Timing
- Latency: one cycle from in_* to out_* when en=1.
- stalled is combinational from stall_req, with no register.
- Flush with en=1 takes effect at the same edge. out_valid=0 is visible the following cycle.
- Flush during stall takes effect at the first non-stalled edge, even if flush has since deasserted.
- Stall and flush both high for several cycles: outputs hold the whole time, then exactly one bubble is loaded.
- Reset asserted mid-stall or with flush_pend=1: reset wins and pending state is discarded.
- NSTALL=1 is legal. NSTALL=0 is not supported.

## Configuration
- PIPE_STALL_STATS_EN defined:
  - stall_cycles increments by 1 on each posedge with en=0, saturating at 16'hFFFF.
  - It clears to 0 on the first posedge with en=1 and on reset.
- PIPE_STALL_STATS_EN undefined: no counter register; stall_cycles is tied to 16'h0000.

## Structure
- Shared package pipe_pkg holds:
  - RESET_PC default 32'h0000_3000
  - NOP encoding 32'h0000_0000
  - stall source index constants STALL_HAZ=0, STALL_BUSY=1, STALL_START=2
  - width constant for stall_cycles (16)
- One sub-module is natural: pipe_stall_ctr, the saturating counter, instantiated only under PIPE_STALL_STATS_EN.
- All other logic lives in pipe_stage_reg.

## Test plan
- Reset: after reset, out_valid=0, out_data=0, out_pc=32'h0000_3000, stall_cycles=0. Then in_data=32'h2408_0005, in_pc=32'h3000, in_valid=1, no stall: next cycle out_data=32'h2408_0005, out_pc=32'h3000.
- Multi-source stall: stall_req=3'b010 for 3 cycles with changing in_data. out_* hold, stalled=1, stall_cycles reaches 3 (stats on). On release the next input loads and stall_cycles returns to 0.
- Live flush: flush=1 with en=1, in_pc=32'h3010, in_bd=1. Next cycle out_valid=0, out_data=0, out_pc=32'h3010, out_bd=1.
- Pending flush: flush pulses 1 cycle while stall_req=3'b001. Outputs hold for the whole stall, then exactly one bubble loads on release. The following cycle loads normally.
- Reset mid-pending: set flush_pend via stall+flush, then assert reset. After reset, release the stall and present in_valid=1, in_data=32'h8C09_0000: it loads unmodified with no bubble.
- Saturation (stats on): stall held for 65540 cycles. stall_cycles=16'hFFFF and holds. With the macro undefined, stall_cycles=0 throughout.
